spi_cfg_controller: RTL
=======================

SPI_CFG_CONTROLLER -- requirements
Module: spi_cfg_controller

Interface
REQ-001 Parameter: CLK_DIV, 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter: GAP_CYCLES, 4, minimum nCS-high cycles between frames; legal range 2..255.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1  write request from requester 0 / 1.
REQ-006 Port: addr0 / addr1  input  7  target register address for requester 0 / 1.
REQ-007 Port: data0 / data1  input  8  write data for requester 0 / 1.
REQ-008 Port: ack0 / ack1  output  1  one-cycle pulse when that request is latched.
REQ-009 Port: busy  output  1  high from the ack cycle through the end of GAP.
REQ-010 Port: done  output  1  one-cycle pulse when nCS deasserts at frame end.
REQ-011 Port: SCLK  output  1  serial clock, idle low (SPI mode 0).
REQ-012 Port: nCS  output  1  chip select, active low.
REQ-013 Port: COPI  output  1  serial data, MSB first.

Function
REQ-014 The FSM SHALL have the states IDLE, SETUP, SHIFT and GAP; all outputs SHALL be registered.
REQ-015 Frame SHALL be 16 bits: bit15=1 (write), bits14:8=addr, bits7:0=data.
REQ-016 Arbitration SHALL occur only in IDLE; requests asserted in other states SHALL wait without loss.
REQ-017 IDLE with a granted req sampled high at edge T: at T+1 ackN=1 for one cycle, frame latched, nCS=0, COPI=bit15, busy=1, state SETUP.
REQ-018 Requester SHALL hold addr/data stable while req is high and before ack; it may drop req in the cycle after ack; req still high after ack SHALL be treated as a new request.
REQ-019 SETUP SHALL last CLK_DIV cycles with SCLK=0, then enter SHIFT.
REQ-020 SHIFT: each bit SHALL be SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles; COPI SHALL change only at the high-to-low SCLK transition.
REQ-021 After 16 high phases and the final low phase, nCS SHALL go high, done SHALL pulse in the same cycle, and state SHALL go to GAP; nCS low time SHALL be exactly 33*CLK_DIV cycles.
REQ-022 A 5-bit bit counter SHALL terminate SHIFT at exactly 16 rising SCLK edges; no partial or extra edges.
REQ-023 GAP SHALL hold nCS=1, SCLK=0 for GAP_CYCLES cycles, then return to IDLE with busy=0.
REQ-024 COPI SHALL be 0 whenever nCS=1.
REQ-025 Back-to-back: a req held high during a frame SHALL be acked on the first IDLE cycle after GAP.

Reset
REQ-026 rst sampled high SHALL, at that edge: state=IDLE, nCS=1, SCLK=0, COPI=0, ack0=ack1=0, busy=0, done=0, bit counter=0, arbitration pointer=requester 0.
REQ-027 rst mid-frame SHALL abort the frame with no done pulse; nCS high on the next edge ends the partial frame.

Configuration
REQ-028 Macro SPI_CFG_RR_ARB_EN defined: round-robin arbitration; on simultaneous req0 and req1 the requester not granted last wins; the pointer updates only on grant.
REQ-029 Macro SPI_CFG_RR_ARB_EN undefined: fixed priority; req0 always wins and req1 is granted only when req0 is low in IDLE.

Verification
REQ-030 CLK_DIV=4: req0, addr0=7'h04, data0=8'hA5 -> ack0 one cycle later; COPI serial 16'h84A5 MSB first; nCS low 132 cycles; done pulse once.
REQ-031 req0 and req1 asserted in the same cycle after reset, held -> with the macro: frames granted 0,1,0,1; without the macro: req0 only, while req1 stays unacked.
REQ-032 req1 raised mid-frame of requester 0 -> ack1 exactly GAP_CYCLES+1 cycles after done; nCS high for at least GAP_CYCLES cycles between frames.
REQ-033 rst pulsed after the 7th SCLK rising edge -> next edge nCS=1, SCLK=0, busy=0, no done; a new req0 then produces a complete correct frame.
REQ-034 Throughout all tests assert: COPI stable while SCLK high, exactly 16 rising edges per nCS-low window, and ack/done are never wider than one cycle.

Source files
------------

// File: rtl/spi_cfg_controller_if.sv
// Request/serial bus bundle for spi_cfg_controller.
// master: the controller side (takes write requests, drives the SPI pins).
// slave : the requester/peripheral side.
interface spi_cfg_controller_if;
  logic       req0;
  logic       req1;
  logic [6:0] addr0;
  logic [6:0] addr1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       nCS;
  logic       COPI;

  modport master (
    input  req0, req1, addr0, addr1, data0, data1,
    output ack0, ack1, busy, done, SCLK, nCS, COPI
  );

  modport slave (
    output req0, req1, addr0, addr1, data0, data1,
    input  ack0, ack1, busy, done, SCLK, nCS, COPI
  );
endinterface

// File: rtl/spi_cfg_controller.sv
// Two-requester SPI register-write controller (mode 0, 16-bit frames:
// 1'b1, addr[6:0], data[7:0], MSB first).
// Optional macro SPI_CFG_RR_ARB_EN: round-robin arbitration between the two
// requesters; when undefined, requester 0 has fixed priority.
module spi_cfg_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  spi_cfg_controller_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_div;
  logic [4:0]  r_bitcnt;
  logic [14:0] r_shift;
  logic        r_sclk;
  logic        r_ncs;
  logic        r_copi;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_busy;
  logic        r_done;
`ifdef SPI_CFG_RR_ARB_EN
  logic        r_prio;
`endif

  logic        w_grant_any;
  logic        w_grant1;
  logic [15:0] w_frame;

  // Arbitration and frame assembly for the requester that would be granted now
  always_comb begin
    w_grant_any = bus.req0 || bus.req1;
`ifdef SPI_CFG_RR_ARB_EN
    // r_prio=1 means requester 1 was not granted last and wins a tie
    w_grant1 = bus.req1 && (!bus.req0 || r_prio);
`else
    w_grant1 = bus.req1 && !bus.req0;
`endif
    w_frame = w_grant1 ? {1'b1, bus.addr1, bus.data1}
                       : {1'b1, bus.addr0, bus.data0};
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT (16 bits) -> GAP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_sclk   <= 1'b0;
      r_ncs    <= 1'b1;
      r_copi   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SPI_CFG_RR_ARB_EN
      r_prio   <= 1'b0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_ack0   <= !w_grant1;
            r_ack1   <= w_grant1;
            r_copi   <= w_frame[15];
            r_shift  <= w_frame[14:0];
            r_ncs    <= 1'b0;
            r_busy   <= 1'b1;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_state  <= S_SETUP;
`ifdef SPI_CFG_RR_ARB_EN
            r_prio   <= !w_grant1;
`endif
          end
        end
        S_SETUP: begin
          if (r_div == DIV_LAST) begin
            r_div    <= '0;
            r_sclk   <= 1'b1;
            r_bitcnt <= r_bitcnt + 5'd1;
            r_state  <= S_SHIFT;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SHIFT: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (r_sclk) begin
              // falling SCLK: present the next bit
              r_sclk  <= 1'b0;
              r_copi  <= r_shift[14];
              r_shift <= {r_shift[13:0], 1'b0};
            end else if (r_bitcnt == 5'd16) begin
              r_ncs   <= 1'b1;
              r_copi  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_GAP;
            end else begin
              r_sclk   <= 1'b1;
              r_bitcnt <= r_bitcnt + 5'd1;
            end
          end
        end
        S_GAP: begin
          if (r_div == GAP_LAST) begin
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0 = r_ack0;
  assign bus.ack1 = r_ack1;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.SCLK = r_sclk;
  assign bus.nCS  = r_ncs;
  assign bus.COPI = r_copi;

endmodule
